// File: rtl/sprite_pixel_shifter_pkg.sv
// Shared constants and unit state encoding for the sprite pixel shifter.
package sprite_pixel_shifter_pkg;

    localparam int unsigned NUM_SPRITES = 8;
    localparam int unsigned LINE_W      = 24;
    localparam int unsigned X_W         = 9;
    localparam int unsigned XPOS_W      = 10;
    localparam int unsigned CNT_W       = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } unit_state_e;

    // Dots a line occupies on screen, depending on horizontal expansion.
    function automatic logic [CNT_W-1:0] line_dots(input logic xe);
        return xe ? CNT_W'(48) : CNT_W'(24);
    endfunction

endpackage

// File: rtl/sprite_pixel_shifter_unit.sv
// One sprite unit: pending line latch, trigger on X match, and the
// hires/multicolor/expand pixel shifter with a registered 2-bit output.
module sprite_shifter_unit
    import sprite_pixel_shifter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              dot_i,
    input  logic [XPOS_W-1:0] xpos_i,
    input  logic [X_W-1:0]    x_i,
    input  logic              xe_i,
    input  logic              mmc_i,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [1:0]        pixel_o,
    output logic              active_o
);

    unit_state_e       state_q, state_d;
    logic [LINE_W-1:0] pend_q, pend_d, shift_q, shift_d, shifted;
    logic              armed_q, armed_d;
    logic              xe_ph_q, xe_ph_d, mc_ph_q, mc_ph_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nxt;
    logic [1:0]        pix_q, pix_d;
    logic              step;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
            xe_ph_q <= 1'b0;
            mc_ph_q <= 1'b0;
            cnt_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            xe_ph_q <= xe_ph_d;
            mc_ph_q <= mc_ph_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        shift_d = shift_q;
        armed_d = armed_q;
        xe_ph_d = xe_ph_q;
        mc_ph_d = mc_ph_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        step    = xe_i ? xe_ph_q : 1'b1;
        shifted = shift_q;
        cnt_nxt = cnt_q + CNT_W'(1);

        if (dot_i) begin
            if (!en_i) begin
                state_d = IDLE;
                armed_d = 1'b0;
                pix_d   = '0;
            end else if (state_q == SHIFT) begin
                if (step) begin
                    if (!mmc_i)      shifted = shift_q << 1;
                    else if (mc_ph_q) shifted = shift_q << 2;
                    mc_ph_d = mmc_i ? ~mc_ph_q : 1'b0;
                end
                xe_ph_d = xe_i ? ~xe_ph_q : 1'b0;
                shift_d = shifted;
                cnt_d   = cnt_nxt;
                // >= so a mid-line xe 1->0 change past dot 24 still ends the line
                if (cnt_nxt >= line_dots(xe_i)) begin
                    state_d = armed_q ? ARMED : IDLE;
                    pix_d   = '0;
                end else begin
                    pix_d = shifted[LINE_W-1 -: 2];
                end
            end else if (state_q == ARMED && armed_q && xpos_i == {1'b0, x_i}) begin
                state_d = SHIFT;
                shift_d = pend_q;
                armed_d = 1'b0;
                xe_ph_d = 1'b0;
                mc_ph_d = 1'b0;
                cnt_d   = '0;
                pix_d   = pend_q[LINE_W-1 -: 2];
            end
        end

        // Applied after the trigger so a coincident load stays pending.
        if (load_i) begin
            pend_d  = data_i;
            armed_d = 1'b1;
            if (state_d == IDLE) state_d = ARMED;
        end
    end

    always_comb begin
        active_o = (state_q == SHIFT);
        pixel_o  = pix_q;
    end

endmodule

// File: rtl/sprite_pixel_shifter.sv
// Top: un-flattens per-sprite buses into NUM shifter units and, when
// SPRITE_COLLISION_EN is defined, accumulates sticky sprite-sprite hits.
module sprite_pixel_shifter
    import sprite_pixel_shifter_pkg::*;
#(
    parameter int unsigned NUM = NUM_SPRITES
) (
    input  logic                  clk_dot4x,
    input  logic                  rst,
    input  logic                  dot_rising_1,
    input  logic [XPOS_W-1:0]     xpos,
    input  logic [NUM*X_W-1:0]    sprite_x_o,
    input  logic [NUM-1:0]        sprite_xe,
    input  logic [NUM-1:0]        sprite_mmc,
    input  logic [NUM-1:0]        sprite_en,
    input  logic [NUM-1:0]        sprite_load,
    input  logic [NUM*LINE_W-1:0] sprite_data_o,
    input  logic                  m2m_clr,
    output logic [NUM*2-1:0]      sprite_cur_pixel_o,
    output logic [NUM-1:0]        sprite_active,
    output logic [NUM-1:0]        m2m_hit
);

    for (genvar n = 0; n < NUM; n++) begin : g_unit
        sprite_shifter_unit u_unit (
            .clk_i    (clk_dot4x),
            .rst_ni   (rst),
            .dot_i    (dot_rising_1),
            .xpos_i   (xpos),
            .x_i      (sprite_x_o[(NUM-1-n)*X_W +: X_W]),
            .xe_i     (sprite_xe[n]),
            .mmc_i    (sprite_mmc[n]),
            .en_i     (sprite_en[n]),
            .load_i   (sprite_load[n]),
            .data_i   (sprite_data_o[(NUM-1-n)*LINE_W +: LINE_W]),
            .pixel_o  (sprite_cur_pixel_o[(NUM-1-n)*2 +: 2]),
            .active_o (sprite_active[n])
        );
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM-1:0] hit_q, hit_d, opaque;
    logic [1:0]     pix;
    int unsigned    n_opaque;

    // Evaluated from the pixels currently on screen at each dot.
    always_comb begin
        opaque   = '0;
        n_opaque = 0;
        pix      = '0;
        for (int unsigned n = 0; n < NUM; n++) begin
            pix       = sprite_cur_pixel_o[(NUM-1-n)*2 +: 2];
            opaque[n] = sprite_mmc[n] ? (pix != 2'b00) : pix[1];
            n_opaque  = n_opaque + {31'b0, opaque[n]};
        end
        hit_d = m2m_clr ? '0 : hit_q;
        if (dot_rising_1 && n_opaque >= 2) hit_d = hit_d | opaque;
    end

    always_ff @(posedge clk_dot4x or negedge rst) begin
        if (!rst) hit_q <= '0;
        else      hit_q <= hit_d;
    end

    assign m2m_hit = hit_q;
`else
    logic unused_m2m_clr;
    assign unused_m2m_clr = m2m_clr;
    assign m2m_hit        = '0;
`endif

endmodule
